load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit.sv | 210 +++++++++++++++++++++
 tb/tb_load_store_unit.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Load/store unit: sequences byte/half/word loads and stores against a
// word-wide synchronous memory (read data valid one cycle after address).
// Sub-word stores are done as read-modify-write of the containing word.
// Optional feature macro: LSU_MISALIGN_TRAP_EN -- when defined, misaligned
// H/W accesses and illegal funct3 codes complete with err=1 and no memory
// access; when undefined, err is always 0, misaligned accesses use the lane
// with the low offset bits cleared, and illegal funct3 acts as a word access.
module load_store_unit #(
    parameter int unsigned N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_store,
    input  logic [2:0]   funct3,
    input  logic [N-1:0] addr,
    input  logic [N-1:0] store_data,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic [N-1:0] load_data,
    output logic         mem_we,
    output logic [N-1:0] mem_addr,
    output logic [N-1:0] mem_data_write,
    input  logic [N-1:0] mem_data_read
);

    localparam int unsigned SIZE_W = 2;
    localparam int unsigned LANE_W = 2;
    localparam logic [SIZE_W-1:0] SZ_B = 2'd0;
    localparam logic [SIZE_W-1:0] SZ_H = 2'd1;
    localparam logic [SIZE_W-1:0] SZ_W = 2'd2;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        RD   = 3'd1,
        CAP  = 3'd2,
        WR   = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic                is_store_q, is_store_d;
    logic [SIZE_W-1:0]   size_q, size_d;
    logic                uns_q, uns_d;
    logic [LANE_W-1:0]   lane_q, lane_d;
    logic [N-1:0]        sdata_q, sdata_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                err_q, err_d;
    logic                mem_we_q, mem_we_d;
    logic [N-1:0]        load_data_q, load_data_d;
    logic [N-1:0]        mem_addr_q, mem_addr_d;
    logic [N-1:0]        mem_wdata_q, mem_wdata_d;

    logic [SIZE_W-1:0]   req_size_c;
    logic                req_uns_c;
    logic [LANE_W-1:0]   req_lane_c;
    logic                req_bad_c;
    logic [7:0]          rd_byte_c;
    logic [15:0]         rd_half_c;
    logic [N-1:0]        load_ext_c;
    logic [N-1:0]        merged_c;

    // Decode the incoming request: access size, extension and byte lane
    always_comb begin
        req_size_c = SZ_W;
        req_uns_c  = 1'b0;
        case (funct3)
            3'd0:    req_size_c = SZ_B;
            3'd1:    req_size_c = SZ_H;
            3'd2:    req_size_c = SZ_W;
            3'd4: begin req_size_c = SZ_B; req_uns_c = 1'b1; end
            3'd5: begin req_size_c = SZ_H; req_uns_c = 1'b1; end
            default: req_size_c = SZ_W;
        endcase
        // Stores have no unsigned forms; treat those codes as word stores
        if (is_store && funct3[2]) begin
            req_size_c = SZ_W;
            req_uns_c  = 1'b0;
        end
        case (req_size_c)
            SZ_B:    req_lane_c = addr[1:0];
            SZ_H:    req_lane_c = {addr[1], 1'b0};
            default: req_lane_c = 2'b00;
        endcase
`ifdef LSU_MISALIGN_TRAP_EN
        req_bad_c = (funct3 == 3'd3) || (funct3 == 3'd6) || (funct3 == 3'd7)
                 || (is_store && funct3[2])
                 || (req_size_c == SZ_H && addr[0])
                 || (req_size_c == SZ_W && addr[1:0] != 2'b00);
`else
        req_bad_c = 1'b0;
`endif
    end

    // Lane extraction/extension of the read word and sub-word store merge
    always_comb begin
        rd_byte_c = mem_data_read[{lane_q, 3'b000} +: 8];
        rd_half_c = mem_data_read[{lane_q[1], 4'b0000} +: 16];
        case (size_q)
            SZ_B:    load_ext_c = {{(N-8){rd_byte_c[7] & ~uns_q}}, rd_byte_c};
            SZ_H:    load_ext_c = {{(N-16){rd_half_c[15] & ~uns_q}}, rd_half_c};
            default: load_ext_c = mem_data_read;
        endcase
        merged_c = mem_data_read;
        if (size_q == SZ_B) begin
            merged_c[{lane_q, 3'b000} +: 8] = sdata_q[7:0];
        end else begin
            merged_c[{lane_q[1], 4'b0000} +: 16] = sdata_q[15:0];
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        size_d      = size_q;
        uns_d       = uns_q;
        lane_d      = lane_q;
        sdata_d     = sdata_q;
        load_data_d = load_data_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    if (req_bad_c) begin
                        state_d = DONE;
                        err_d   = 1'b1;
                    end else begin
                        is_store_d = is_store;
                        size_d     = req_size_c;
                        uns_d      = req_uns_c;
                        lane_d     = req_lane_c;
                        sdata_d    = store_data;
                        mem_addr_d = {addr[N-1:2], 2'b00};
                        if (is_store && req_size_c == SZ_W) begin
                            mem_wdata_d = store_data;
                            state_d     = WR;
                        end else begin
                            state_d = RD;
                        end
                    end
                end
            end
            RD:   state_d = CAP;
            CAP: begin
                if (is_store_q) begin
                    mem_wdata_d = merged_c;
                    state_d     = WR;
                end else begin
                    load_data_d = load_ext_c;
                    state_d     = DONE;
                end
            end
            WR:   state_d = DONE;
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        busy_d   = (state_d == RD) || (state_d == CAP) || (state_d == WR);
        done_d   = (state_d == DONE);
        mem_we_d = (state_d == WR);
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            is_store_q  <= 1'b0;
            size_q      <= SZ_B;
            uns_q       <= 1'b0;
            lane_q      <= '0;
            sdata_q     <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_we_q    <= 1'b0;
            load_data_q <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            size_q      <= size_d;
            uns_q       <= uns_d;
            lane_q      <= lane_d;
            sdata_q     <= sdata_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_we_q    <= mem_we_d;
            load_data_q <= load_data_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err            = err_q;
    assign mem_we         = mem_we_q;
    assign load_data      = load_data_q;
    assign mem_addr       = mem_addr_q;
    assign mem_data_write = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed reference cases, randomized requests
// against a byte-arithmetic reference model, and mid-transaction reset.
module tb_load_store_unit;

    localparam int unsigned N = 32;
    localparam logic [31:0] BASE = 32'h0010_0000;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         start = 1'b0;
    logic         is_store = 1'b0;
    logic [2:0]   funct3 = 3'd0;
    logic [N-1:0] addr = '0;
    logic [N-1:0] store_data = '0;
    logic         busy, done, err, mem_we;
    logic [N-1:0] load_data, mem_addr, mem_data_write;
    logic [N-1:0] mem_data_read;

    load_store_unit #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .is_store(is_store),
        .funct3(funct3), .addr(addr), .store_data(store_data),
        .busy(busy), .done(done), .err(err), .load_data(load_data),
        .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data_write(mem_data_write), .mem_data_read(mem_data_read)
    );

    always #5 clk = ~clk;

    // 16-word memory window; contents loaded from init_mem when load_mem is high
    logic [31:0] mem [16];
    logic [31:0] init_mem [16];
    logic        load_mem = 1'b0;
    int          wr_count = 0;
    always @(posedge clk) begin
        if (load_mem) begin
            for (int i = 0; i < 16; i++) mem[i] <= init_mem[i];
        end else if (mem_we) begin
            mem[mem_addr[5:2]] <= mem_data_write;
            wr_count <= wr_count + 1;
        end
        mem_data_read <= mem[mem_addr[5:2]];
    end

    // Reference model state
    logic [31:0] ref_mem [16];
    logic [31:0] ref_ld = 32'h0;

    int n_asserts = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: applies one request to ref_mem/ref_ld, returns latency and err
    function automatic void ref_req(input logic st, input logic [2:0] f3,
                                    input logic [31:0] a, input logic [31:0] d,
                                    output int lat, output logic e);
        int sz;
        bit uns;
        bit illegal;
        int off;
        int idx;
        longint unsigned mask, w, v;
        uns = 0;
        illegal = 0;
        case (f3)
            3'd0: sz = 1;
            3'd1: sz = 2;
            3'd2: sz = 4;
            3'd4: begin sz = 1; uns = 1; end
            3'd5: begin sz = 2; uns = 1; end
            default: begin sz = 4; illegal = 1; end
        endcase
        if (st && f3 > 3'd2) begin sz = 4; uns = 0; illegal = 1; end
`ifdef LSU_MISALIGN_TRAP_EN
        e = illegal || ((a % sz) != 0);
`else
        e = 1'b0;
`endif
        if (e) begin
            lat = 1;
            return;
        end
        off  = int'(a % 4) - (int'(a % 4) % sz);
        idx  = int'((a / 4) % 16);
        mask = (64'd1 << (8 * sz)) - 64'd1;
        w    = 64'(ref_mem[idx]);
        if (!st) begin
            v = (w >> (8 * off)) & mask;
            if (!uns && sz < 4 && v >= (mask + 64'd1) / 2) v = v | (64'hFFFF_FFFF & ~mask);
            ref_ld = 32'(v);
            lat = 3;
        end else begin
            w = (w & ~(mask << (8 * off))) | ((64'(d) & mask) << (8 * off));
            ref_mem[idx] = 32'(w);
            lat = (sz == 4) ? 2 : 4;
        end
    endfunction

    // Issue one request, track its completion, compare against the model
    task automatic run(input logic st, input logic [2:0] f3, input logic [31:0] a,
                       input logic [31:0] d);
        int lat_exp, k, we_k, wr0;
        logic e_exp;
        bit busy_bad;
        @(negedge clk);
        is_store = st; funct3 = f3; addr = a; store_data = d; start = 1'b1;
        ref_req(st, f3, a, d, lat_exp, e_exp);
        wr0 = wr_count; k = 0; we_k = -1; busy_bad = 0;
        @(posedge clk);
        do begin
            @(negedge clk);
            k++;
            if (mem_we) we_k = k;
            if (!done && !busy) busy_bad = 1;
            start = 1'($urandom);
            is_store = 1'($urandom);
            funct3 = 3'($urandom);
            addr = $urandom;
            store_data = $urandom;
        end while (!done && k < 10);
        start = 1'b0;
        check("latency", 32'(k), 32'(lat_exp));
        check("err", 32'(err), 32'(e_exp));
        check("busy_at_done", 32'(busy), 32'd0);
        check("busy_during", 32'(busy_bad), 32'd0);
        check("load_data", load_data, ref_ld);
        check("write_count", 32'(wr_count - wr0), (st && !e_exp) ? 32'd1 : 32'd0);
        if (st && !e_exp) begin
            check("we_cycle", 32'(we_k), 32'(lat_exp - 1));
            check("mem_word", mem[a[5:2]], ref_mem[a[5:2]]);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
        check({tag, "_we"}, 32'(mem_we), 32'd0);
        check({tag, "_ld"}, load_data, 32'd0);
        check({tag, "_maddr"}, mem_addr, 32'd0);
        check({tag, "_wdata"}, mem_data_write, 32'd0);
    endtask

    initial begin
        logic [2:0] f3;
        logic [31:0] a, d, word_before;
        int wr0;
        bit saw_done;

        for (int i = 0; i < 16; i++) begin
            init_mem[i] = $urandom;
        end
        init_mem[0] = 32'h8899_AABB;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_mem[i];

        #1 rst = 1'b1;
        #1 check_reset_outputs("reset");
        load_mem = 1'b1;
        @(posedge clk);
        @(negedge clk);
        load_mem = 1'b0;
        rst = 1'b0;

        // Directed reference cases
        run(1'b0, 3'd0, BASE + 32'd1, 32'h0);
        check("lb_value", load_data, 32'hFFFF_FFAA);
        run(1'b0, 3'd5, BASE + 32'd2, 32'h0);
        check("lhu_value", load_data, 32'h0000_8899);
        run(1'b1, 3'd0, BASE + 32'd3, 32'h0000_0011);
        check("sb_word", mem[0], 32'h1199_AABB);
        check("ld_after_store", load_data, 32'h0000_8899);
        run(1'b1, 3'd2, BASE + 32'd4, 32'hDEAD_BEEF);
        run(1'b0, 3'd2, BASE + 32'd4, 32'h0);
        check("lw_readback", load_data, 32'hDEAD_BEEF);
        run(1'b1, 3'd1, BASE + 32'd6, 32'h1234_CAFE);
        run(1'b0, 3'd1, BASE + 32'd6, 32'h0);
        check("lh_sign", load_data, 32'hFFFF_CAFE);
`ifdef LSU_MISALIGN_TRAP_EN
        run(1'b0, 3'd2, BASE + 32'd2, 32'h0);
        check("trap_ld_kept", load_data, 32'hFFFF_CAFE);
        run(1'b1, 3'd1, BASE + 32'd1, 32'h5555_5555);
        run(1'b0, 3'd3, BASE, 32'h0);
`endif

        // Randomized requests
        for (int t = 0; t < 80; t++) begin
            case ($urandom_range(0, 6))
                0: f3 = 3'd0;
                1: f3 = 3'd1;
                2: f3 = 3'd2;
                3: f3 = 3'd4;
                4: f3 = 3'd5;
                5: f3 = 3'd2;
                default: f3 = 3'($urandom);
            endcase
            a = BASE + 32'($urandom_range(0, 63));
            d = $urandom;
            run(1'($urandom), f3, a, d);
        end

        // Reset while an SH sits in CAP: no write, no done, word intact
        a = BASE + 32'd10;
        word_before = mem[2];
        @(negedge clk);
        is_store = 1'b1; funct3 = 3'd1; addr = a; store_data = 32'hA5A5_5A5A; start = 1'b1;
        wr0 = wr_count;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        #1 check_reset_outputs("midrst");
        ref_ld = 32'h0;
        @(negedge clk);
        rst = 1'b0;
        saw_done = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (done) saw_done = 1;
        end
        check("midrst_no_done", 32'(saw_done), 32'd0);
        check("midrst_no_write", 32'(wr_count - wr0), 32'd0);
        check("midrst_word", mem[2], word_before);
        run(1'b0, 3'd2, BASE + 32'd8, 32'h0);
        check("midrst_lw", load_data, word_before);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
